// File: rtl/uart_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared types and helpers for the UART transmitter/receiver
//               family: parity modes, transmitter FSM states, frame length.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Parity selection, encoded as the PARITY_MODE parameter value
    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2
    } parity_mode_e;

    // Transmitter frame sequencing states
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;

    // Number of bit periods in one frame: start + data + optional parity + stop
    function automatic int frame_len(input int data_bits,
                                     input int parity_mode,
                                     input int stop_bits);
        return 1 + data_bits + ((parity_mode != 0) ? 1 : 0) + stop_bits;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_sync_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : uart_sync_fifo
// Description : Single-clock FIFO with a registered head word. The head
//               register always holds the oldest queued word, so a consumer
//               can take dout in the same cycle it asserts pop.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic [WIDTH-1:0]         dout
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] w_rd_ptr_nxt;
    logic [PTR_W:0]   r_count;
    logic [WIDTH-1:0] r_dout;
    logic [WIDTH-1:0] w_dout_next;
    logic             w_do_push;
    logic             w_do_pop;

    // A full FIFO refuses pushes even when a pop happens in the same cycle
    assign w_do_push    = push && !full;
    assign w_do_pop     = pop && !empty;
    assign w_rd_ptr_nxt = r_rd_ptr + PTR_W'(1);

    assign full  = (r_count == (PTR_W+1)'(DEPTH));
    assign empty = (r_count == '0);
    assign count = r_count;
    assign dout  = r_dout;

    // Storage array write port; contents need no reset since count gates use
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Next head word: the following entry after a pop, or the incoming word
    // when it lands in an otherwise empty queue
    always_comb begin
        w_dout_next = r_dout;
        if (w_do_pop) begin
            if (r_count > (PTR_W+1)'(1)) begin
                w_dout_next = r_mem[w_rd_ptr_nxt];
            end else if (w_do_push) begin
                w_dout_next = din;
            end
        end else if (w_do_push && empty) begin
            w_dout_next = din;
        end
    end

    // Pointers, occupancy and head register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_dout   <= '0;
        end else begin
            r_dout <= w_dout_next;
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= w_rd_ptr_nxt;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_param.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : uart_tx_param
// Description : Parametrised UART transmitter with input FIFO. Frames are
//               start, DATA_BITS data (LSB first), optional parity and
//               STOP_BITS stop bits, paced by an external baud tick.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int DATA_BITS   = 8,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 1,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          baud_tick,
    input  logic [DATA_BITS-1:0]          tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          tx_busy,
    output logic                          tx_out,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          frame_done
);

    localparam parity_mode_e PMODE     = parity_mode_e'(PARITY_MODE);
    localparam bit           HAS_PARITY = (PMODE != PAR_NONE);
    localparam int           FRAME_LEN  = frame_len(DATA_BITS, PARITY_MODE, STOP_BITS);
    // Counter only ever spans a sub-field of the frame; sizing by the whole
    // frame keeps it wide enough for every legal configuration
    localparam int           CNT_W      = $clog2(FRAME_LEN);
    localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_BITS - 1);
    localparam logic [CNT_W-1:0] LAST_STOP = CNT_W'(STOP_BITS - 1);

    tx_state_e              r_state;
    tx_state_e              w_state_next;
    logic [DATA_BITS-1:0]   r_shift;
    logic [DATA_BITS-1:0]   w_shift_next;
    logic                   r_parity;
    logic                   w_parity_next;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       w_cnt_next;
    logic                   w_pop;
    logic                   w_frame_done;
    logic                   w_line;
    logic                   r_tx_out;
    logic                   r_frame_done;

    logic                   w_fifo_full;
    logic                   w_fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] w_fifo_count;
    logic [DATA_BITS-1:0]   w_fifo_head;
    logic                   w_head_parity;

    uart_sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tx_valid && tx_ready),
        .pop   (w_pop),
        .din   (tx_data),
        .full  (w_fifo_full),
        .empty (w_fifo_empty),
        .count (w_fifo_count),
        .dout  (w_fifo_head)
    );

    // Parity of the word about to be loaded, latched with it at pop time
    generate
        if (PMODE == PAR_NONE) begin : g_no_parity
            assign w_head_parity = 1'b0;
        end else if (PMODE == PAR_ODD) begin : g_odd_parity
            assign w_head_parity = ~(^w_fifo_head);
        end else begin : g_even_parity
            assign w_head_parity = ^w_fifo_head;
        end
    endgenerate

    // Next-state logic: every transition is gated by the baud tick
    always_comb begin
        w_state_next  = r_state;
        w_shift_next  = r_shift;
        w_parity_next = r_parity;
        w_cnt_next    = r_cnt;
        w_pop         = 1'b0;
        w_frame_done  = 1'b0;
        if (baud_tick) begin
            unique case (r_state)
                IDLE: begin
                    if (!w_fifo_empty) begin
                        w_pop         = 1'b1;
                        w_shift_next  = w_fifo_head;
                        w_parity_next = w_head_parity;
                        w_cnt_next    = '0;
                        w_state_next  = START;
                    end
                end
                START: begin
                    w_cnt_next   = '0;
                    w_state_next = DATA;
                end
                DATA: begin
                    w_shift_next = r_shift >> 1;
                    if (r_cnt == LAST_DATA) begin
                        w_cnt_next = '0;
                        if (HAS_PARITY) begin
                            w_state_next = PARITY;
                        end else begin
                            w_state_next = STOP;
                        end
                    end else begin
                        w_cnt_next = r_cnt + CNT_W'(1);
                    end
                end
                PARITY: begin
                    w_cnt_next   = '0;
                    w_state_next = STOP;
                end
                STOP: begin
                    if (r_cnt == LAST_STOP) begin
                        w_frame_done = 1'b1;
                        w_cnt_next   = '0;
                        // Chain straight into the next start bit when work is queued
                        if (!w_fifo_empty) begin
                            w_pop         = 1'b1;
                            w_shift_next  = w_fifo_head;
                            w_parity_next = w_head_parity;
                            w_state_next  = START;
                        end else begin
                            w_state_next = IDLE;
                        end
                    end else begin
                        w_cnt_next = r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    w_state_next = IDLE;
                end
            endcase
        end
    end

    // Line level implied by the current state
    always_comb begin
        w_line = 1'b1;
        case (r_state)
            START:   w_line = 1'b0;
            DATA:    w_line = r_shift[0];
            PARITY:  w_line = r_parity;
            default: w_line = 1'b1;
        endcase
    end

    // State, shifter and counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_shift  <= '0;
            r_parity <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_state  <= w_state_next;
            r_shift  <= w_shift_next;
            r_parity <= w_parity_next;
            r_cnt    <= w_cnt_next;
        end
    end

    // Registered line and end-of-frame pulse, one clk behind the state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_out     <= 1'b1;
            r_frame_done <= 1'b0;
        end else begin
            r_tx_out     <= w_line;
            r_frame_done <= w_frame_done;
        end
    end

    assign tx_out     = r_tx_out;
    assign frame_done = r_frame_done;
    assign tx_ready   = !w_fifo_full;
    assign fifo_count = w_fifo_count;
    assign tx_busy    = (r_state != IDLE) || (w_fifo_count != '0);

endmodule
`default_nettype wire
